// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller driving one external full_adder cell,
// LSB first over WIDTH cycles, with valid/ready handshakes on both sides.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_cnt == CNT_LAST);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                fa_a   = r_a[0];
                fa_b   = r_b[0];
                fa_cin = r_carry;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= op_a;
                        r_b     <= sub ? ~op_b : op_b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_result <= {fa_sum, r_result[WIDTH-1:1]};
                    r_carry  <= fa_cout;
                    if (w_last) begin
                        r_carry_out <= fa_cout;
                        // carry into the MSB differs from carry out of it
                        r_overflow  <= r_carry ^ fa_cout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a behavioural full adder.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic       overflow;
    logic       busy;
    logic       fa_a;
    logic       fa_b;
    logic       fa_cin;
    logic       fa_sum;
    logic       fa_cout;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one request, then follow RUN until out_valid (bounded).
    task automatic start_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic [7:0] exp_fb);
        int         lat;
        logic [7:0] fa_seq;
        logic [7:0] fb_seq;
        logic       cin0;
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 'x; op_b = 'x; sub = 1'bx;
        chk({tag, "_busy_run"}, busy, 1);
        chk({tag, "_in_ready_run"}, in_ready, 0);
        lat = 0; fa_seq = '0; fb_seq = '0; cin0 = fa_cin;
        while (!out_valid && lat < 20) begin
            if (lat < 8) begin
                fa_seq[lat] = fa_a;
                fb_seq[lat] = fa_b;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_fa_a_seq"}, fa_seq, a);
        chk({tag, "_fa_b_seq"}, fb_seq, exp_fb);
        chk({tag, "_fa_cin0"}, cin0, s);
    endtask

    task automatic check_res(input string tag, input logic [7:0] r, input logic co, input logic ov);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_result"}, result, r);
        chk({tag, "_carry_out"}, carry_out, co);
        chk({tag, "_overflow"}, overflow, ov);
        chk({tag, "_fa_a_done"}, fa_a, 0);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_idle"}, out_valid, 0);
        chk({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        start_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h01);
        check_res("add_0f_01", 8'h10, 1'b0, 1'b0);
        finish_op("add_0f_01");

        start_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h01);
        check_res("add_ff_01", 8'h00, 1'b1, 1'b0);
        finish_op("add_ff_01");

        start_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h01);
        check_res("add_7f_01", 8'h80, 1'b0, 1'b1);
        finish_op("add_7f_01");

        // Backpressure with new operands offered while DONE
        start_op("bp", 8'h20, 8'h03, 1'b0, 8'h03);
        check_res("bp", 8'h23, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op_a = 8'hAA; op_b = 8'h55; sub = 1'b1;
            @(posedge clk); #1;
            chk("bp_out_valid_hold", out_valid, 1);
            chk("bp_in_ready_hold", in_ready, 0);
            chk("bp_result_hold", {carry_out, overflow, result}, {2'b00, 8'h23});
        end
        in_valid = 1'b0;
        finish_op("bp");
        chk("bp_result_kept_idle", result, 8'h23);
        chk("bp_busy_idle", busy, 0);

        start_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hF8);
        check_res("sub_05_07", 8'hFE, 1'b0, 1'b0);
        finish_op("sub_05_07");

        start_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'hFE);
        check_res("sub_80_01", 8'h7F, 1'b1, 1'b1);
        finish_op("sub_80_01");

        // Asynchronous reset in the 3rd RUN cycle
        op_a = 8'h55; op_b = 8'h11; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_fa_a_run3", fa_a, 1);
        chk("mid_busy_run3", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_fa", {fa_a, fa_b, fa_cin}, 0);
        chk("mid_result", result, 0);
        chk("mid_flags", {out_valid, carry_out, overflow}, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        start_op("add_12_34", 8'h12, 8'h34, 1'b0, 8'h34);
        check_res("add_12_34", 8'h46, 1'b0, 1'b0);
        finish_op("add_12_34");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller that time-shares one external full_adder cell over WIDTH cycles, LSB first. It holds the operand shift registers, the carry flip-flop and the result register, and exposes valid/ready handshakes on both sides. It sits between a requesting datapath and a single full_adder instance. This trades area for latency where a WIDTH-bit ripple adder is too large.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operands present
in_ready  out  1  controller can accept operands
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
sub  in  1  0 = A+B, 1 = A-B
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  WIDTH  sum or difference
carry_out  out  1  final carry (subtract: 1 = no borrow)
overflow  out  1  signed two's-complement overflow
busy  out  1  high in RUN or DONE
fa_a  out  1  to full_adder input a
fa_b  out  1  to full_adder input b
fa_cin  out  1  to full_adder input cin
fa_sum  in  1  from full_adder sum, combinational same cycle
fa_cout  in  1  from full_adder cout, combinational same cycle

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - All registers cleared.
  - Outputs: in_ready=1 once out of reset; out_valid=0, result=0, carry_out=0, overflow=0, busy=0, fa_a=fa_b=fa_cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; fa_* driven 0.
  - On in_valid & in_ready:
    - A_sr <= op_a.
    - B_sr <= sub ? ~op_b : op_b.
    - carry <= sub.
    - cnt <= 0.
    - Go to RUN.
  - Operands are sampled only on this edge.
- RUN:
  - in_ready=0; fa_a=A_sr[0], fa_b=B_sr[0], fa_cin=carry.
  - Each edge:
    - A_sr and B_sr shift right by one.
    - result shifts right with fa_sum entering at MSB.
    - carry <= fa_cout.
    - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1:
    - carry_out <= fa_cout.
    - overflow <= carry ^ fa_cout (carry into MSB XOR carry out of MSB).
    - Go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1; fa_* driven 0.
  - result, carry_out and overflow are held stable until out_valid & out_ready; then go to IDLE.
  - out_valid stays high indefinitely under backpressure.
- Latency: out_valid rises WIDTH clock edges after the accepting edge. Minimum initiation interval is WIDTH+2 cycles.
- No overlap: in_valid during RUN or DONE is ignored (in_ready=0). A new request is accepted only in the cycle after the DONE handshake.
- result keeps its last value in IDLE. out_valid=0 qualifies it.
- Counter width is clog2(WIDTH). There is no wrap-around beyond WIDTH-1.
- Reset mid-operation aborts immediately. No partial result is ever presented.
- X on op_a/op_b/sub while not accepting has no effect on state.

Test Plan:
- Add 0x0F+0x01 (WIDTH=8):
  - fa_a sequence 1,1,1,1,0,0,0,0.
  - out_valid exactly 8 cycles after accept.
  - result=0x10, carry_out=0, overflow=0.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0.
- Add 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
- Subtract:
  - 0x05-0x07 -> result=0xFE, carry_out=0, overflow=0.
  - 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid while driving in_valid with new operands.
  - Required: result/flags stable, in_ready=0, new operands ignored.
  - Raise out_ready: IDLE next cycle, in_ready=1.
- Reset mid-RUN:
  - Assert rst_n=0 asynchronously on the 3rd RUN cycle.
  - Required: outputs zero without waiting for a clock edge.
  - After release, 0x12+0x34 -> result=0x46 with correct 8-cycle latency.
